// File: rtl/app_mac_acc.sv
// app_mac_acc: sums a programmed number of multiplier products and hands the result on with a valid/ready handshake.
// Build option APP_MAC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module app_mac_acc #(
    parameter int IN_W  = 32,
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic             clk_w,
    input  logic             rst_w,
    input  logic             start_w,
    input  logic [LEN_W-1:0] len_w,
    input  logic [IN_W-1:0]  prod_w,
    input  logic             prod_valid_w,
    output logic             prod_ready_w,
    output logic [ACC_W-1:0] acc_w,
    output logic             acc_valid_w,
    input  logic             acc_ready_w,
    output logic             busy_w,
    output logic             ovf_w
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t           state;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len_reg;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] next_acc;
    assign sum = {1'b0, acc_w} + {{(ACC_W + 1 - IN_W){1'b0}}, prod_w};
`ifdef APP_MAC_SAT_EN
    assign next_acc = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    assign next_acc = sum[ACC_W-1:0];
`endif
    always_ff @(posedge clk_w) begin
        if (rst_w) begin
            state        <= IDLE;
            acc_w        <= '0;
            count        <= '0;
            len_reg      <= '0;
            ovf_w        <= 1'b0;
            prod_ready_w <= 1'b0;
            acc_valid_w  <= 1'b0;
            busy_w       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_w) begin
                    len_reg      <= len_w;
                    acc_w        <= '0;
                    count        <= '0;
                    ovf_w        <= 1'b0;
                    busy_w       <= 1'b1;
                    state        <= (len_w != '0) ? ACC : DONE;
                    prod_ready_w <= (len_w != '0);
                    acc_valid_w  <= (len_w == '0);
                end
                ACC: if (prod_valid_w) begin
                    acc_w <= next_acc;
                    ovf_w <= ovf_w | sum[ACC_W];
                    count <= count + 1'b1;
                    if (count == len_reg - 1'b1) begin
                        state        <= DONE;
                        prod_ready_w <= 1'b0;
                        acc_valid_w  <= 1'b1;
                    end
                end
                DONE: if (acc_ready_w) begin
                    state       <= IDLE;
                    acc_valid_w <= 1'b0;
                    busy_w      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_app_mac_acc.sv
// tb_app_mac_acc: randomized self-checking bench for app_mac_acc (40-bit and 32-bit accumulator instances).
module tb_app_mac_acc;
    logic        clk_w = 1'b0;
    logic        rst_w, start_w, prod_valid_w, acc_ready_w;
    logic [7:0]  len_w;
    logic [31:0] prod_w;
    logic        pr40, av40, busy40, ovf40, pr32, av32, busy32, ovf32;
    logic [39:0] acc40;
    logic [31:0] acc32;
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] prods[$];
    int          r_cyc, r_gaps, r_rdy_bad, r_hold_bad;
    logic        r_rdy_any, r_busy_after, r_o40, r_o32;
    logic [39:0] r_a40;
    logic [31:0] r_a32;

    app_mac_acc #(.IN_W(32), .ACC_W(40), .LEN_W(8)) dut40 (
        .clk_w(clk_w), .rst_w(rst_w), .start_w(start_w), .len_w(len_w), .prod_w(prod_w),
        .prod_valid_w(prod_valid_w), .prod_ready_w(pr40), .acc_w(acc40), .acc_valid_w(av40),
        .acc_ready_w(acc_ready_w), .busy_w(busy40), .ovf_w(ovf40));
    app_mac_acc #(.IN_W(32), .ACC_W(32), .LEN_W(8)) dut32 (
        .clk_w(clk_w), .rst_w(rst_w), .start_w(start_w), .len_w(len_w), .prod_w(prod_w),
        .prod_valid_w(prod_valid_w), .prod_ready_w(pr32), .acc_w(acc32), .acc_valid_w(av32),
        .acc_ready_w(acc_ready_w), .busy_w(busy32), .ovf_w(ovf32));

    always #5 clk_w = ~clk_w;

    // Reference: exact sum of the run, then wrapped or saturated to w bits.
    function automatic void model(input int w, input int len, output logic [63:0] res, output logic ovf);
        longint unsigned total = 0;
        longint unsigned lim = 64'd1 << w;
        for (int i = 0; i < len; i++) total += 64'(prods[i]);
        ovf = (total >= lim);
`ifdef APP_MAC_SAT_EN
        res = ovf ? lim - 1 : total;
`else
        res = total % lim;
`endif
    endfunction

    // Drives one complete run and records what the DUTs showed.
    task automatic do_run(input int len, input int gmin, input int gmax, input int hold, input bit mid_start);
        int cyc, t, g;
        r_rdy_bad = 0; r_hold_bad = 0; r_rdy_any = 1'b0; r_gaps = 0;
        @(negedge clk_w);
        start_w = 1'b1; len_w = len[7:0]; prod_valid_w = 1'b0; acc_ready_w = 1'b0;
        @(negedge clk_w);
        start_w = 1'b0; cyc = 2; r_rdy_any |= pr40;
        for (int i = 0; i < len; i++) begin
            g = (i > 0) ? $urandom_range(gmax, gmin) : 0;
            r_gaps += g;
            repeat (g) begin
                prod_w = $urandom;
                @(negedge clk_w);
                cyc++; r_rdy_any |= pr40;
            end
            prod_w = prods[i]; prod_valid_w = 1'b1;
            if (mid_start && i == 0) begin start_w = 1'b1; len_w = 8'd9; end
            if (!pr40 || !pr32) r_rdy_bad++;
            @(negedge clk_w);
            cyc++; start_w = 1'b0; prod_valid_w = 1'b0; prod_w = $urandom; r_rdy_any |= pr40;
        end
        t = 0;
        while (!av40 && t < 40) begin
            @(negedge clk_w);
            cyc++; t++; r_rdy_any |= pr40;
        end
        r_cyc = av40 ? cyc : -1;
        r_a40 = acc40; r_o40 = ovf40; r_a32 = acc32; r_o32 = ovf32;
        repeat (hold) begin
            @(negedge clk_w);
            if (acc40 !== r_a40 || acc32 !== r_a32 || ovf40 !== r_o40 || ovf32 !== r_o32 || !av40 || !av32)
                r_hold_bad++;
        end
        acc_ready_w = 1'b1;
        if (mid_start) begin start_w = 1'b1; len_w = 8'd9; end
        @(negedge clk_w);
        acc_ready_w = 1'b0; start_w = 1'b0;
        r_busy_after = busy40 | busy32 | av40 | av32;
    endtask

    task automatic test_reset;
        rst_w = 1'b1; start_w = 1'b0; len_w = '0; prod_w = '0; prod_valid_w = 1'b0; acc_ready_w = 1'b0;
        repeat (2) @(negedge clk_w);
        n_checks++;
        if ({pr40, av40, busy40, ovf40, pr32, av32, busy32, ovf32} !== 8'b0) begin
            n_fail++; $display("FAIL reset_flags got %b want 00000000", {pr40, av40, busy40, ovf40, pr32, av32, busy32, ovf32});
        end
        n_checks++;
        if (acc40 !== 40'd0 || acc32 !== 32'd0) begin
            n_fail++; $display("FAIL reset_acc got %h/%h want 0", acc40, acc32);
        end
        rst_w = 1'b0;
    endtask

    task automatic test_basic;
        prods = '{32'd100, 32'd200, 32'd300};
        do_run(3, 0, 0, 0, 1'b0);
        n_checks++;
        if (r_cyc != 5) begin n_fail++; $display("FAIL basic_latency got %0d want 5", r_cyc); end
        n_checks++;
        if (r_a40 !== 40'd600 || r_o40 !== 1'b0) begin n_fail++; $display("FAIL basic_sum got %0d ovf %b want 600 ovf 0", r_a40, r_o40); end
        n_checks++;
        if (r_busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_idle got busy %b want 0", r_busy_after); end
    endtask

    task automatic test_backpressure;
        logic [31:0] e32;
        prods = '{32'hFFFF_FFFF, 32'd1};
        do_run(2, 2, 2, 4, 1'b0);
`ifdef APP_MAC_SAT_EN
        e32 = 32'hFFFF_FFFF;
`else
        e32 = 32'd0;
`endif
        n_checks++;
        if (r_a40 !== 40'h1_0000_0000 || r_o40 !== 1'b0) begin n_fail++; $display("FAIL bp_sum40 got %h ovf %b want 100000000 ovf 0", r_a40, r_o40); end
        n_checks++;
        if (r_a32 !== e32 || r_o32 !== 1'b1) begin n_fail++; $display("FAIL bp_sum32 got %h ovf %b want %h ovf 1", r_a32, r_o32, e32); end
        n_checks++;
        if (r_cyc != 6) begin n_fail++; $display("FAIL bp_latency got %0d want 6", r_cyc); end
        n_checks++;
        if (r_hold_bad != 0) begin n_fail++; $display("FAIL bp_hold got %0d unstable cycles want 0", r_hold_bad); end
        n_checks++;
        if (r_busy_after !== 1'b0) begin n_fail++; $display("FAIL bp_idle got busy %b want 0", r_busy_after); end
    endtask

    task automatic test_zero_len;
        prods.delete();
        do_run(0, 0, 0, 1, 1'b0);
        n_checks++;
        if (r_cyc != 2) begin n_fail++; $display("FAIL zero_latency got %0d want 2", r_cyc); end
        n_checks++;
        if (r_a40 !== 40'd0 || r_o40 !== 1'b0) begin n_fail++; $display("FAIL zero_sum got %h ovf %b want 0", r_a40, r_o40); end
        n_checks++;
        if (r_rdy_any !== 1'b0) begin n_fail++; $display("FAIL zero_ready got %b want 0", r_rdy_any); end
    endtask

    task automatic test_overflow;
        logic [31:0] e32;
        prods = '{32'hFFFF_FFFF, 32'd2};
        do_run(2, 0, 1, 2, 1'b0);
`ifdef APP_MAC_SAT_EN
        e32 = 32'hFFFF_FFFF;
`else
        e32 = 32'd1;
`endif
        n_checks++;
        if (r_a32 !== e32 || r_o32 !== 1'b1) begin n_fail++; $display("FAIL ovf_sum32 got %h ovf %b want %h ovf 1", r_a32, r_o32, e32); end
        n_checks++;
        if (r_a40 !== 40'h1_0000_0001 || r_o40 !== 1'b0) begin n_fail++; $display("FAIL ovf_sum40 got %h ovf %b want 100000001 ovf 0", r_a40, r_o40); end
    endtask

    task automatic test_reset_mid_run;
        bit seen = 1'b0;
        @(negedge clk_w);
        start_w = 1'b1; len_w = 8'd4;
        @(negedge clk_w);
        start_w = 1'b0;
        repeat (2) begin
            prod_w = $urandom; prod_valid_w = 1'b1;
            @(negedge clk_w);
        end
        prod_w = 32'd55; rst_w = 1'b1;
        @(negedge clk_w);
        rst_w = 1'b0; prod_valid_w = 1'b0;
        n_checks++;
        if (busy40 !== 1'b0 || acc40 !== 40'd0 || av40 !== 1'b0 || pr40 !== 1'b0 || ovf40 !== 1'b0) begin
            n_fail++; $display("FAIL midrst_state got busy %b acc %h valid %b ready %b want all 0", busy40, acc40, av40, pr40);
        end
        repeat (6) begin
            @(negedge clk_w);
            seen |= av40 | av32 | busy40;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL midrst_no_output got activity 1 want 0"); end
        prods = '{32'd7};
        do_run(1, 0, 0, 0, 1'b0);
        n_checks++;
        if (r_a40 !== 40'd7 || r_cyc != 3) begin n_fail++; $display("FAIL midrst_rerun got %0d at cycle %0d want 7 at 3", r_a40, r_cyc); end
    endtask

    task automatic test_ignored_start;
        prods = '{32'd5, 32'd6, 32'd100, 32'd100};
        do_run(2, 0, 0, 1, 1'b1);
        n_checks++;
        if (r_a40 !== 40'd11 || r_cyc != 4) begin n_fail++; $display("FAIL ign_start got %0d at cycle %0d want 11 at 4", r_a40, r_cyc); end
        n_checks++;
        if (r_busy_after !== 1'b0) begin n_fail++; $display("FAIL ign_start_done got busy %b want 0", r_busy_after); end
    endtask

    task automatic test_random;
        logic [63:0] e40, e32;
        logic        eo40, eo32;
        int          len;
        for (int r = 0; r < 24; r++) begin
            len = (r == 0) ? 255 : $urandom_range(12, 1);
            prods.delete();
            for (int i = 0; i < len; i++)
                prods.push_back((r % 3 == 0) ? 32'hFFFF_FF00 | 32'($urandom_range(255)) : $urandom);
            do_run(len, 0, 2, $urandom_range(3), 1'b0);
            model(40, len, e40, eo40);
            model(32, len, e32, eo32);
            n_checks++;
            if ({24'd0, r_a40} !== e40 || r_o40 !== eo40) begin n_fail++; $display("FAIL rand_sum40 run %0d got %h ovf %b want %h ovf %b", r, r_a40, r_o40, e40, eo40); end
            n_checks++;
            if ({32'd0, r_a32} !== e32 || r_o32 !== eo32) begin n_fail++; $display("FAIL rand_sum32 run %0d got %h ovf %b want %h ovf %b", r, r_a32, r_o32, e32, eo32); end
            n_checks++;
            if (r_cyc != len + 2 + r_gaps) begin n_fail++; $display("FAIL rand_latency run %0d got %0d want %0d", r, r_cyc, len + 2 + r_gaps); end
            n_checks++;
            if (r_rdy_bad != 0 || r_hold_bad != 0 || r_busy_after !== 1'b0) begin
                n_fail++; $display("FAIL rand_handshake run %0d got rdy_bad %0d hold_bad %0d busy %b want 0 0 0", r, r_rdy_bad, r_hold_bad, r_busy_after);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_overflow();
        test_reset_mid_run();
        test_ignored_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/app_mac_acc.md
Name: app_mac_acc

Overview:
- Accumulation stage directly downstream of the 16x16 approximate multiplier.
- Consumes its 32-bit unsigned products one per beat and sums a programmed number of them into a wide accumulator, for example one dot product or one output pixel.
- Presents the finished sum to the next stage with a valid/ready handshake.
- The multiplier stays purely combinational; this block supplies the sequencing, beat counting and overflow handling around it.

Parameters:
- IN_W, 32, product width; matches the multiplier output.
- ACC_W, 40, accumulator width; must be >= IN_W.
- LEN_W, 8, width of the beat-count field; maximum run length is 2^LEN_W - 1.

Ports:
- clk_w  input  1  clock; all logic is on the rising edge.
- rst_w  input  1  reset; synchronous, active-high.
- start_w  input  1  pulse that begins a run; sampled only in IDLE.
- len_w  input  LEN_W  number of products in the run; sampled with start_w.
- prod_w  input  IN_W  product from the multiplier.
- prod_valid_w  input  1  prod_w is valid.
- prod_ready_w  output  1  block accepts prod_w this cycle.
- acc_w  output  ACC_W  accumulated sum.
- acc_valid_w  output  1  acc_w holds a finished result.
- acc_ready_w  input  1  downstream accepts acc_w.
- busy_w  output  1  high whenever the state is not IDLE.
- ovf_w  output  1  sticky overflow flag for the current run; valid together with acc_w.

Behaviour:
- Reset (synchronous; rst_w wins over every other input):
  - state=IDLE, acc_w=0, count=0, len_reg=0, ovf_w=0.
  - prod_ready_w=0, acc_valid_w=0, busy_w=0.
  - Asserting reset mid-run discards the partial sum and any in-flight beat; there is no output for that run.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - prod_ready_w=0.
  - On start_w=1: latch len_reg=len_w, clear acc_w to 0, clear count to 0, clear ovf_w to 0.
  - Go to ACC if len_w!=0, otherwise go to DONE, which yields acc_w=0.
- ACC:
  - prod_ready_w=1 (registered-state decode, no combinational path from prod_valid_w).
  - A beat is accepted when prod_valid_w && prod_ready_w: acc_w <= acc_w + zero-extended prod_w, and count <= count+1.
  - When the accepted beat has count==len_reg-1, go to DONE. That beat's addition is included in the result.
  - Bubbles (prod_valid_w=0) stall the run with no change; there is no timeout.
- DONE:
  - acc_valid_w=1 and prod_ready_w=0; acc_w and ovf_w are held stable.
  - On acc_ready_w=1, go to IDLE. acc_w keeps its value until the next start_w clears it.
- start_w outside IDLE is ignored, including in the DONE handshake cycle. Back-to-back runs therefore need one IDLE cycle between them.
- Latency: acc_valid_w rises on the cycle after the last accepted product. A run of N beats with no bubbles takes N+2 cycles from start_w to acc_valid_w.
- Arithmetic (unsigned):
  - Sum computed at ACC_W+1 bits; a carry out of bit ACC_W-1 sets ovf_w, which stays set for the rest of the run.
  - Default: the result wraps modulo 2^ACC_W.
- len_w=2^LEN_W-1 is legal and uses the full count range; count never wraps within a run.

Optional Feature:
- Macro: APP_MAC_SAT_EN.
- Defined: on carry out, acc_w saturates to all-ones (2^ACC_W-1). Later additions in the same run keep it at all-ones, and ovf_w is set as usual.
- Undefined: modulo-2^ACC_W wrap as described in Behaviour; ovf_w is still reported.

Test Plan:
- Basic run: start_w with len_w=3, products 100, 200, 300 with no bubbles -> acc_valid_w on cycle 5 after start, acc_w=600, ovf_w=0.
- Bubbles and backpressure: len_w=2, products 0xFFFF_FFFF then 1, with 2 idle cycles between them; hold acc_ready_w=0 for 4 cycles -> acc_w=0x1_0000_0000, held stable while acc_valid_w=1; IDLE the cycle after acc_ready_w=1.
- Zero length: len_w=0 -> prod_ready_w never asserted, acc_valid_w=1 two cycles after start, acc_w=0.
- Overflow: ACC_W=32, len_w=2, products 0xFFFF_FFFF and 2 -> without the macro acc_w=1, ovf_w=1; with APP_MAC_SAT_EN acc_w=0xFFFF_FFFF, ovf_w=1.
- Reset mid-run: len_w=4, accept 2 beats, pulse rst_w -> the next cycle is IDLE with acc_w=0, busy_w=0, acc_valid_w never asserted; a new run with len_w=1 and product 7 gives acc_w=7.
- Ignored start: pulse start_w with len_w=9 during ACC (len_w=2, products 5, 6) -> acc_w=11 after exactly 2 beats.
